// File: rtl/sqrt_sched_pkg.sv
// Shared types and sizing helpers for the square-root job scheduler.
package sqrt_sched_pkg;

    // Scheduler states:
    //   state    | meaning
    //   ST_IDLE  | arbitrating, req_ready driven for the winner
    //   ST_START | first engine-enable cycle, engine samples operand
    //   ST_RUN   | engine iterating, watchdog counting
    //   ST_RESP  | result held on the response bus until accepted
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Number of engine iterations for a given operand format.
    function automatic int iter_limit(input int width, input int f_bits);
        return (width + f_bits) / 2;
    endfunction

    // Width of a requester index; a single bit minimum keeps ports legal.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Watchdog counter width able to hold the timeout value itself.
    function automatic int wd_width(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

    localparam int ID_W_DEF = 2;
    localparam int WD_W_DEF = 7;

endpackage

// File: rtl/sqrt_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first request at or after the pointer.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any_req
);

    logic found;

    // Scan N positions starting at the pointer, wrapping past N-1 to 0.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        any_req = |req;
        for (int k = 0; k < N; k++) begin : scan
            int             pos;
            logic [PTR_W-1:0] idx;
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = PTR_W'(pos);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/sqrt_scheduler.sv
// Shares one square-root engine among N_REQ requesters with a watchdog.
//   state    | meaning
//   ST_IDLE  | waiting for a request, grants one in the accept cycle
//   ST_START | engine enabled for the first time, operand sampled
//   ST_RUN   | waiting for eng_valid or watchdog expiry
//   ST_RESP  | response presented to the granted requester
module sqrt_scheduler
    import sqrt_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 48,
    parameter int F_BITS      = 28,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_radicand,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_root,
    output logic [WIDTH-1:0]       rsp_rem,
    output logic                   rsp_err,
    output logic                   eng_enable,
    output logic [WIDTH-1:0]       eng_radicand,
    input  logic                   eng_busy,
    input  logic                   eng_valid,
    input  logic [WIDTH-1:0]       eng_root,
    input  logic [WIDTH-1:0]       eng_rem,
    output logic                   sched_busy,
    output logic [7:0]             err_cnt
);

    localparam int ID_W = id_width(N_REQ);
    localparam int WD_W = wd_width(TIMEOUT_CYC);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WIDTH-1:0]  rad_q, rad_d;
    logic [WIDTH-1:0]  root_q, root_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              err_q, err_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [N_REQ-1:0]  gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic              any_req;
    logic [WIDTH-1:0]  sel_rad;

    // Busy from the engine is informational; sequencing relies on timing.
    logic unused_eng_busy;
    assign unused_eng_busy = eng_busy;

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_req (any_req)
    );

    // Pick the winning requester's radicand slice.
    always_comb begin
        sel_rad = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_rad = req_radicand[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot response valid for the latched requester while in RESP.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = (state_q == ST_RESP) && (id_q == ID_W'(i));
        end
    end

    // Next-state logic, engine enable and request accept.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        rad_d      = rad_q;
        root_d     = root_q;
        rem_d      = rem_q;
        err_d      = err_q;
        wd_d       = wd_q;
        err_cnt_d  = err_cnt_q;
        req_ready  = '0;
        eng_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    req_ready = gnt;
                    id_d      = gnt_idx;
                    rad_d     = sel_rad;
                    ptr_d     = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                eng_enable = 1'b1;
                wd_d       = '0;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                eng_enable = 1'b1;
                if (eng_valid) begin
                    root_d  = eng_root;
                    rem_d   = eng_rem;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    // This cycle is the last one the engine is allowed.
                    root_d  = '0;
                    rem_d   = '0;
                    err_d   = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d = ST_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (|(rsp_valid & rsp_ready)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            rad_q     <= '0;
            root_q    <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
            wd_q      <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            rad_q     <= rad_d;
            root_q    <= root_d;
            rem_q     <= rem_d;
            err_q     <= err_d;
            wd_q      <= wd_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign eng_radicand = rad_q;
    assign rsp_root     = root_q;
    assign rsp_rem      = rem_q;
    assign rsp_err      = err_q;
    assign sched_busy   = (state_q != ST_IDLE);
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_sqrt_scheduler.sv
// Directed bench for sqrt_scheduler with a behavioural square-root engine.
module tb_sqrt_scheduler;

    localparam int N_REQ = 4;
    localparam int WIDTH = 48;
    localparam int F_BITS = 28;
    localparam int TIMEOUT_CYC = 64;
    localparam int L = (WIDTH + F_BITS) / 2;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_radicand;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]       rsp_root;
    logic [WIDTH-1:0]       rsp_rem;
    logic                   rsp_err;
    logic                   eng_enable;
    logic [WIDTH-1:0]       eng_radicand;
    logic                   eng_busy;
    logic                   eng_valid;
    logic [WIDTH-1:0]       eng_root;
    logic [WIDTH-1:0]       eng_rem;
    logic                   sched_busy;
    logic [7:0]             err_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic eng_hang = 1'b0;
    logic eng_act  = 1'b0;
    int   eng_cnt  = 0;

    sqrt_scheduler #(
        .N_REQ       (N_REQ),
        .WIDTH       (WIDTH),
        .F_BITS      (F_BITS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_radicand (req_radicand),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_root     (rsp_root),
        .rsp_rem      (rsp_rem),
        .rsp_err      (rsp_err),
        .eng_enable   (eng_enable),
        .eng_radicand (eng_radicand),
        .eng_busy     (eng_busy),
        .eng_valid    (eng_valid),
        .eng_root     (eng_root),
        .eng_rem      (eng_rem),
        .sched_busy   (sched_busy),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [79:0] isqrt(input logic [79:0] v);
        logic [79:0] r;
        logic [79:0] t;
        r = '0;
        for (int b = 39; b >= 0; b--) begin
            t = r | (80'd1 << b);
            if (t * t <= v) r = t;
        end
        return r;
    endfunction

    // Engine model: samples on first enabled cycle, strobes L+1 cycles later.
    always @(negedge clk) begin
        logic [79:0] v;
        logic [79:0] r;
        if (rst || !eng_enable) begin
            eng_act   = 1'b0;
            eng_cnt   = 0;
            eng_valid = 1'b0;
            eng_busy  = 1'b0;
        end else if (!eng_act) begin
            eng_act   = 1'b1;
            eng_busy  = 1'b1;
            eng_cnt   = 0;
            eng_valid = 1'b0;
            v = 80'(eng_radicand) << F_BITS;
            r = isqrt(v);
            eng_root = r[WIDTH-1:0];
            eng_rem  = 48'(v - r * r);
        end else begin
            eng_cnt   = eng_cnt + 1;
            eng_valid = (eng_cnt == L + 1) && !eng_hang;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input int id, input logic [47:0] rad, input logic [47:0] root,
                           input logic [47:0] rem, input logic err, input int lat);
        int n;
        logic [N_REQ-1:0] one;
        one = 4'b0001 << id;
        @(negedge clk);
        req_radicand[id*WIDTH +: WIDTH] = rad;
        req_valid = one;
        #1;
        check("req_ready", 64'(req_ready), 64'(one));
        @(negedge clk);
        req_valid = '0;
        n = 1;
        while (rsp_valid == '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), 64'(lat));
        check("rsp_valid", 64'(rsp_valid), 64'(one));
        check("rsp_root", 64'(rsp_root), 64'(root));
        check("rsp_rem", 64'(rsp_rem), 64'(rem));
        check("rsp_err", 64'(rsp_err), 64'(err));
        @(negedge clk);
        check("idle_after", 64'(sched_busy), 64'd0);
    endtask

    initial begin
        int n;
        int cyc;
        int last;
        int guard;
        int seen;
        logic [N_REQ-1:0] one;

        rst          = 1'b1;
        req_valid    = '0;
        req_radicand = '0;
        rsp_ready    = '1;
        eng_valid    = 1'b0;
        eng_busy     = 1'b0;
        eng_root     = '0;
        eng_rem      = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_eng_enable", 64'(eng_enable), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(sched_busy), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_root", 64'(rsp_root), 64'd0);
        check("rst_eng_rad", 64'(eng_radicand), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single jobs: 1.0, 4.0 and 2.0
        run_job(0, 48'h1000_0000, 48'h1000_0000, 48'd0, 1'b0, 41);
        run_job(2, 48'h4000_0000, 48'h2000_0000, 48'd0, 1'b0, 41);
        run_job(2, 48'h2000_0000, 48'h16A0_9E66, 48'd377352028, 1'b0, 41);

        // Backpressure on requester 1 (9.0 -> 3.0)
        @(negedge clk);
        rsp_ready = 4'b1101;
        req_radicand[1*WIDTH +: WIDTH] = 48'h9000_0000;
        req_valid = 4'b0010;
        #1;
        check("bp_req_ready", 64'(req_ready), 64'b0010);
        @(negedge clk);
        req_valid = '0;
        n = 1;
        while (rsp_valid == '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("bp_latency", 64'(n), 64'd41);
        req_valid = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 64'(rsp_valid), 64'b0010);
            check("bp_rsp_root", 64'(rsp_root), 64'h3000_0000);
            check("bp_eng_enable", 64'(eng_enable), 64'd0);
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        check("bp_rsp_rem", 64'(rsp_rem), 64'd0);
        req_valid = '0;
        rsp_ready = 4'b1111;
        @(negedge clk);
        check("bp_released", 64'(rsp_valid), 64'd0);
        check("bp_idle", 64'(sched_busy), 64'd0);

        // Timeout, then a normal job (1/16 -> 1/4)
        eng_hang = 1'b1;
        run_job(3, 48'h1000_0000, 48'd0, 48'd0, 1'b1, 66);
        check("to_err_cnt", 64'(err_cnt), 64'd1);
        eng_hang = 1'b0;
        run_job(0, 48'h0100_0000, 48'h0400_0000, 48'd0, 1'b0, 41);
        check("to_err_cnt_hold", 64'(err_cnt), 64'd1);

        // Reset in the middle of a job
        @(negedge clk);
        req_radicand[0 +: WIDTH] = 48'h4000_0000;
        req_valid = 4'b0001;
        #1;
        check("mid_req_ready", 64'(req_ready), 64'b0001);
        @(negedge clk);
        req_valid = '0;
        repeat (19) @(negedge clk);
        check("mid_running", 64'(eng_enable), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_eng_enable", 64'(eng_enable), 64'd0);
        check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_busy", 64'(sched_busy), 64'd0);
        check("mid_err_cnt", 64'(err_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (45) begin
            @(negedge clk);
            if (rsp_valid != '0) seen++;
        end
        check("mid_no_rsp", 64'(seen), 64'd0);
        run_job(1, 48'h0400_0000, 48'h0800_0000, 48'd0, 1'b0, 41);

        // Round-robin with all requesters held from reset
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N_REQ; i++) req_radicand[i*WIDTH +: WIDTH] = 48'h1000_0000;
        req_valid = '1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        cyc  = 0;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            guard = 0;
            while (req_ready == '0 && guard < 100) begin
                @(negedge clk);
                cyc++;
                guard++;
            end
            one = 4'b0001 << (g % N_REQ);
            check("rr_grant", 64'(req_ready), 64'(one));
            if (g > 0) check("rr_spacing", 64'(cyc - last), 64'd42);
            last = cyc;
            @(negedge clk);
            cyc++;
        end
        req_valid = '0;
        guard = 0;
        while (rsp_valid == '0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("rr_last_rsp", 64'(rsp_valid), 64'b0001);
        check("rr_last_root", 64'(rsp_root), 64'h1000_0000);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sqrt_scheduler.md
Name: sqrt_scheduler

Overview:
Shares one fixed-point square-root engine among N_REQ requesters. Each requester has its own valid/ready request channel and response channel. A round-robin arbiter grants one job at a time; the block sequences the engine's enable/valid protocol, captures the result and returns it to the granted requester. A watchdog converts a missing engine result into an error response.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 48, radicand/root/remainder width
F_BITS, 28, fractional bits; iterations L = (WIDTH+F_BITS)/2
TIMEOUT_CYC, 64, engine cycles allowed before error response (must exceed L+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  N_REQ  per-requester job request
req_ready  out  N_REQ  one-hot accept, asserted only in the accept cycle
req_radicand  in  N_REQ*WIDTH  packed radicands, slice i = requester i
rsp_valid  out  N_REQ  one-hot response valid
rsp_ready  in  N_REQ  per-requester response accept
rsp_root  out  WIDTH  shared result bus
rsp_rem  out  WIDTH  shared remainder bus
rsp_err  out  1  response is a timeout error
eng_enable  out  1  engine enable (level)
eng_radicand  out  WIDTH  engine operand, held stable while eng_enable=1
eng_busy  in  1  engine busy
eng_valid  in  1  engine one-cycle result strobe
eng_root  in  WIDTH  engine root, sampled only when eng_valid=1
eng_rem  in  WIDTH  engine remainder, sampled only when eng_valid=1
sched_busy  out  1  job in flight (state != IDLE)
err_cnt  out  8  saturating timeout counter

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; RR pointer 0; latched id/radicand/result 0.
- Engine contract: the engine samples eng_radicand on the first eng_enable=1 cycle while idle. eng_valid pulses exactly L+1 cycles after that cycle. Dropping eng_enable clears the engine. eng_enable must be low for at least 1 cycle between jobs.
- States: IDLE, START, RUN, RESP.
- IDLE:
  - If any req_valid, the RR arbiter picks the first set bit at or after the pointer, wrapping.
  - req_ready[g]=1 combinationally in that cycle. Latch g and its radicand. Pointer <= g+1 mod N_REQ. Go to START.
  - If no req_valid, stay in IDLE.
- START: eng_enable=1, eng_radicand=latched value, watchdog cleared. Go to RUN.
- RUN:
  - eng_enable=1; watchdog increments each cycle.
  - On eng_valid: capture eng_root/eng_rem, rsp_err=0, go to RESP. eng_enable is 0 from the next cycle.
  - When watchdog reaches TIMEOUT_CYC: capture root/rem=0, rsp_err=1, err_cnt+1 (saturates at 255), go to RESP.
- RESP:
  - eng_enable=0. rsp_valid[g]=1, and rsp_root/rsp_rem/rsp_err stay stable until rsp_ready[g].
  - On handshake: drop rsp_valid and go to IDLE. The next grant is possible in the following cycle.
  - rsp_ready on non-granted lines is ignored.
- Latency: request accept at cycle 0 → eng_enable cycles 1..L+2 → rsp_valid first asserted at cycle L+3 (41 with defaults). Minimum job period is L+4 cycles with rsp_ready held high.
- Throughput: req_ready is all-zero outside IDLE. Requesters hold req_valid and radicand until accepted.
- Request withdrawn or changed before accept: no effect beyond the current arbitration cycle.
- eng_valid outside RUN: ignored. eng_busy is observational only; it asserts in RUN and is not used for sequencing.
- Reset mid-job: immediate return to IDLE; eng_enable=0; the pending response is lost and no rsp_valid is issued.
- N_REQ not a power of 2: pointer wrap to 0 after N_REQ-1.

Decomposition:
- Package sqrt_sched_pkg:
  - state enum (IDLE, START, RUN, RESP)
  - function iter_limit(WIDTH, F_BITS)
  - localparam widths for requester id ($clog2(N_REQ)) and watchdog counter
- Sub-module rr_arbiter, parameterised on N:
  - inputs: request vector, pointer
  - outputs: one-hot grant, grant index, any_req
  - purely combinational; pointer register stays in sqrt_scheduler

Test Plan:
1. Single request: requester 0, radicand 0x1000_0000 (1.0) → req_ready[0] at cycle 0; rsp_valid[0] at cycle 41; rsp_root=0x1000_0000; rsp_rem=0; rsp_err=0.
2. Exact root: requester 2, radicand 0x4000_0000 (4.0) → rsp_root=0x2000_0000; rsp_rem=0. Irrational root: radicand 0x2000_0000 (2.0) → rsp_root=0x16A0_9E66.
3. Round-robin: all 4 req_valid held high from reset, rsp_ready=1 → grant order 0,1,2,3,0; accepts spaced L+4=42 cycles apart.
4. Backpressure: rsp_ready[1]=0 for 10 cycles → rsp_valid/rsp_root stable; eng_enable=0; req_ready all 0; completes on the first rsp_ready[1]=1.
5. Timeout: engine model never pulses eng_valid → after 64 RUN cycles, rsp_err=1, rsp_root=0, err_cnt=1; the next job runs normally.
6. Reset mid-job: assert rst at cycle 20 of a job → eng_enable, rsp_valid and sched_busy all 0 asynchronously; after release, a new request completes in 41 cycles.
